sample_capture_writer: RTL and testbench

- Upstream stage of the SDRAM playback controller; the write side of the capture path.
- Takes 8-bit ADC samples, packs pairs into 16-bit words and buffers them in a small FIFO.
- Writes the words to SDRAM as an Avalon-MM write master over sequential, wrapping addresses. This is the master selected when SW[0]=1.
- Publishes its write pointer so the read side can check how far ahead of playback the stored data is.

---
 rtl/sample_capture_writer_if.sv | 26 ++
 rtl/sample_capture_writer.sv | 178 +++++++++++++++++
 tb/tb_sample_capture_writer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_capture_writer_if.sv
// Avalon-MM write bus between the capture writer (master) and the SDRAM arbiter (slave).
interface sample_capture_writer_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] avm_address;
  logic [15:0]       avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_writedata,
    output avm_byteenable,
    output avm_write,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_write,
    output avm_waitrequest
  );
endinterface

// File: rtl/sample_capture_writer.sv
// Capture-path write side: packs 8-bit ADC samples into 16-bit words, buffers them
// in a small first-word-fall-through FIFO and streams them to SDRAM over Avalon-MM
// at sequential, wrapping word addresses.
module sample_capture_writer #(
  parameter int                ADDR_W    = 25,
  parameter int                FIFO_LOG2 = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  // All ones is the last word of the 25-bit SDRAM word space.
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                    M100CLK,
  input  logic                    lock,
  input  logic                    enable,
  input  logic [7:0]              sample_in,
  input  logic                    sample_valid,
  sample_capture_writer_if.master avm,
  output logic [ADDR_W-1:0]       wr_ptr,
  output logic [FIFO_LOG2:0]      fifo_level,
  output logic                    overflow,
  output logic                    busy
);

  localparam int                 DEPTH      = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_LEVEL = {1'b1, {FIFO_LOG2{1'b0}}};

  typedef enum logic {IDLE, WRITE} state_t;

  // ---------------- byte packing ----------------
  logic        phase_reg;      // 1: low byte held, waiting for high byte
  logic [7:0]  low_byte_reg;
  logic        push;
  logic [15:0] push_data;

  assign push      = sample_valid & enable & phase_reg;
  assign push_data = {sample_in, low_byte_reg};

  // Track the byte phase; dropping enable discards a half-built word.
  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) begin
      phase_reg    <= 1'b0;
      low_byte_reg <= 8'h00;
    end else if (!enable) begin
      phase_reg <= 1'b0;
    end else if (sample_valid) begin
      if (!phase_reg) low_byte_reg <= sample_in;
      phase_reg <= ~phase_reg;
    end
  end

  // ---------------- word FIFO ----------------
  logic [15:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_idx_reg;
  logic [FIFO_LOG2-1:0] rd_idx_reg;
  logic [FIFO_LOG2-1:0] rd_idx_inc;
  logic [FIFO_LOG2:0]   level_reg;
  logic                 overflow_reg;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic [15:0]          head;
  logic [15:0]          next_head;

  assign full       = (level_reg == FULL_LEVEL);
  // A pop in the same cycle frees the slot, so push-while-full is still fine then.
  assign push_ok    = push & (~full | pop);
  assign rd_idx_inc = rd_idx_reg + 1'b1;
  assign head       = mem[rd_idx_reg];
  assign next_head  = mem[rd_idx_inc];

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge M100CLK) begin
    if (push_ok) mem[wr_idx_reg] <= push_data;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) begin
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_idx_reg <= wr_idx_reg + 1'b1;
      if (pop)     rd_idx_reg <= rd_idx_inc;
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (push & ~push_ok) overflow_reg <= 1'b1;
    end
  end

  // ---------------- Avalon write FSM ----------------
  state_t            state_reg, state_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       data_reg, data_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic              accept;
  logic              more;
  logic [15:0]       next_word;

  assign accept     = (state_reg == WRITE) & write_reg & ~avm.avm_waitrequest;
  assign pop        = accept;
  assign wr_ptr_inc = (wr_ptr_reg == LAST_ADDR) ? BASE_ADDR : wr_ptr_reg + 1'b1;
  // Another word follows the accepted one if it is already queued behind the head,
  // or if it is being pushed right now into an otherwise single-entry FIFO.
  assign more       = (|level_reg[FIFO_LOG2:1]) | push_ok;
  assign next_word  = (|level_reg[FIFO_LOG2:1]) ? next_head : push_data;

  // State and registered bus outputs.
  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) begin
      state_reg  <= IDLE;
      write_reg  <= 1'b0;
      addr_reg   <= BASE_ADDR;
      data_reg   <= 16'h0000;
      wr_ptr_reg <= BASE_ADDR;
    end else begin
      state_reg  <= state_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (level_reg != '0) state_next = WRITE;
      WRITE:   if (accept && !more) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered bus outputs and the write pointer.
  always_comb begin
    write_next  = write_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    wr_ptr_next = wr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          write_next = 1'b1;
          addr_next  = wr_ptr_reg;
          data_next  = head;
        end
      end
      WRITE: begin
        if (accept) begin
          wr_ptr_next = wr_ptr_inc;
          if (more) begin
            addr_next = wr_ptr_inc;
            data_next = next_word;
          end else begin
            write_next = 1'b0;
          end
        end
      end
      default: write_next = 1'b0;
    endcase
  end

  assign avm.avm_address    = addr_reg;
  assign avm.avm_writedata  = data_reg;
  assign avm.avm_byteenable = 2'b11;
  assign avm.avm_write      = write_reg;
  assign wr_ptr             = wr_ptr_reg;
  assign fifo_level         = level_reg;
  assign overflow           = overflow_reg;
  assign busy               = (level_reg != '0) | write_reg;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed bench for sample_capture_writer: a vector table for packing / single
// writes / back-to-back writes, plus hand sequences for stall, overflow, wrap and
// asynchronous reset. Instance dut_b uses LAST_ADDR=3 to exercise the wrap.
module tb_sample_capture_writer;

  logic        clk = 1'b0;
  logic        lock = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  sample_in = 8'h00;
  logic        sample_valid = 1'b0;
  logic        waitreq = 1'b0;

  logic [24:0] wr_ptr_a, wr_ptr_b;
  logic [4:0]  level_a, level_b;
  logic        overflow_a, overflow_b, busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_capture_writer_if #(.ADDR_W(25)) bus_a ();
  sample_capture_writer_if #(.ADDR_W(25)) bus_b ();

  assign bus_a.avm_waitrequest = waitreq;
  assign bus_b.avm_waitrequest = waitreq;

  sample_capture_writer #(.ADDR_W(25), .FIFO_LOG2(4)) dut_a (
    .M100CLK(clk), .lock(lock), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .avm(bus_a), .wr_ptr(wr_ptr_a),
    .fifo_level(level_a), .overflow(overflow_a), .busy(busy_a)
  );

  sample_capture_writer #(.ADDR_W(25), .FIFO_LOG2(4), .BASE_ADDR(25'd0), .LAST_ADDR(25'd3)) dut_b (
    .M100CLK(clk), .lock(lock), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .avm(bus_b), .wr_ptr(wr_ptr_b),
    .fifo_level(level_b), .overflow(overflow_b), .busy(busy_b)
  );

  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  smp;
    logic        wq;
    logic        exp_wr;
    logic [24:0] exp_addr;
    logic [15:0] exp_data;
    logic [4:0]  exp_lvl;
    logic [24:0] exp_ptr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; sample_valid = 1'b0; sample_in = 8'h00; waitreq = 1'b0;
    lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 lock = 1'b1;
  endtask

  task automatic drive(input logic en, input logic vld, input logic [7:0] smp, input logic wq);
    enable = en; sample_valid = vld; sample_in = smp; waitreq = wq;
  endtask

  initial begin
    int seq [6];
    logic [15:0] word;

    // en vld smp wq | write addr data level wr_ptr
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd1, 25'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 25'd0, 16'h2211, 5'd1, 25'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd1};
    vecs[5]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd1};
    vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd1};
    vecs[7]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd1};
    vecs[8]  = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd1, 25'd1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 25'd1, 16'h0201, 5'd1, 25'd1};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd2};
    vecs[11] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd2};
    vecs[12] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd1, 25'd2};
    vecs[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 25'd2, 16'h4433, 5'd1, 25'd2};
    vecs[14] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 25'd3, 16'h6655, 5'd1, 25'd3};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 25'd0, 16'h0000, 5'd0, 25'd4};
    seq = '{0, 1, 2, 3, 0, 1};

    // ---- reset state ----
    do_reset();
    check("rst.write",    {31'd0, bus_a.avm_write}, 32'd0);
    check("rst.addr",     {7'd0, bus_a.avm_address}, 32'd0);
    check("rst.data",     {16'd0, bus_a.avm_writedata}, 32'd0);
    check("rst.be",       {30'd0, bus_a.avm_byteenable}, 32'd3);
    check("rst.wr_ptr",   {7'd0, wr_ptr_a}, 32'd0);
    check("rst.level",    {27'd0, level_a}, 32'd0);
    check("rst.overflow", {31'd0, overflow_a}, 32'd0);
    check("rst.busy",     {31'd0, busy_a}, 32'd0);

    // ---- table: first write, enable drop, back-to-back with push bypass ----
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].smp, vecs[i].wq);
      step();
      check($sformatf("vec%0d.write", i), {31'd0, bus_a.avm_write}, {31'd0, vecs[i].exp_wr});
      check($sformatf("vec%0d.level", i), {27'd0, level_a}, {27'd0, vecs[i].exp_lvl});
      check($sformatf("vec%0d.wr_ptr", i), {7'd0, wr_ptr_a}, {7'd0, vecs[i].exp_ptr});
      check($sformatf("vec%0d.busy", i), {31'd0, busy_a},
            {31'd0, (vecs[i].exp_lvl != 5'd0) || vecs[i].exp_wr});
      check($sformatf("vec%0d.overflow", i), {31'd0, overflow_a}, 32'd0);
      if (vecs[i].exp_wr) begin
        check($sformatf("vec%0d.addr", i), {7'd0, bus_a.avm_address}, {7'd0, vecs[i].exp_addr});
        check($sformatf("vec%0d.data", i), {16'd0, bus_a.avm_writedata}, {16'd0, vecs[i].exp_data});
      end
    end

    // ---- stall: waitrequest held 5 cycles during a write ----
    do_reset();
    drive(1'b1, 1'b1, 8'h5A, 1'b1); step();
    drive(1'b1, 1'b1, 8'hC3, 1'b1); step();
    drive(1'b1, 1'b0, 8'h00, 1'b1); step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.write", k), {31'd0, bus_a.avm_write}, 32'd1);
      check($sformatf("stall%0d.addr", k), {7'd0, bus_a.avm_address}, 32'd0);
      check($sformatf("stall%0d.data", k), {16'd0, bus_a.avm_writedata}, 32'hC35A);
      check($sformatf("stall%0d.level", k), {27'd0, level_a}, 32'd1);
      check($sformatf("stall%0d.wr_ptr", k), {7'd0, wr_ptr_a}, 32'd0);
      if (k < 4) step();
    end
    waitreq = 1'b0;
    step();
    check("stall.rel.write",  {31'd0, bus_a.avm_write}, 32'd0);
    check("stall.rel.level",  {27'd0, level_a}, 32'd0);
    check("stall.rel.wr_ptr", {7'd0, wr_ptr_a}, 32'd1);
    step();
    check("stall.post.level",  {27'd0, level_a}, 32'd0);
    check("stall.post.wr_ptr", {7'd0, wr_ptr_a}, 32'd1);

    // ---- overflow: 36 samples against a stalled slave ----
    do_reset();
    for (int j = 0; j < 36; j++) begin
      drive(1'b1, 1'b1, 8'(j), 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("ovf.level",    {27'd0, level_a}, 32'd16);
    check("ovf.overflow", {31'd0, overflow_a}, 32'd1);
    check("ovf.write",    {31'd0, bus_a.avm_write}, 32'd1);
    check("ovf.addr0",    {7'd0, bus_a.avm_address}, 32'd0);
    check("ovf.data0",    {16'd0, bus_a.avm_writedata}, 32'h0100);
    waitreq = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) begin
        word = {8'(2 * k + 1), 8'(2 * k)};
        check($sformatf("drain%0d.write", k), {31'd0, bus_a.avm_write}, 32'd1);
        check($sformatf("drain%0d.addr", k), {7'd0, bus_a.avm_address}, k);
        check($sformatf("drain%0d.data", k), {16'd0, bus_a.avm_writedata}, {16'd0, word});
        check($sformatf("drain%0d.level", k), {27'd0, level_a}, 16 - k);
      end else begin
        check("drain.end.write",  {31'd0, bus_a.avm_write}, 32'd0);
        check("drain.end.level",  {27'd0, level_a}, 32'd0);
        check("drain.end.wr_ptr", {7'd0, wr_ptr_a}, 32'd16);
        check("drain.end.ovf",    {31'd0, overflow_a}, 32'd1);
      end
    end

    // ---- asynchronous reset in the middle of a stalled write ----
    drive(1'b1, 1'b1, 8'h10, 1'b1); step();
    drive(1'b1, 1'b1, 8'h20, 1'b1); step();
    drive(1'b1, 1'b0, 8'h00, 1'b1); step();
    check("arst.pre.write", {31'd0, bus_a.avm_write}, 32'd1);
    check("arst.pre.addr",  {7'd0, bus_a.avm_address}, 32'd16);
    #2 lock = 1'b0;
    #1;
    check("arst.write",    {31'd0, bus_a.avm_write}, 32'd0);
    check("arst.addr",     {7'd0, bus_a.avm_address}, 32'd0);
    check("arst.wr_ptr",   {7'd0, wr_ptr_a}, 32'd0);
    check("arst.level",    {27'd0, level_a}, 32'd0);
    check("arst.overflow", {31'd0, overflow_a}, 32'd0);
    check("arst.busy",     {31'd0, busy_a}, 32'd0);
    @(posedge clk);
    #1 lock = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    check("arst.rel.write",  {31'd0, bus_a.avm_write}, 32'd0);
    check("arst.rel.wr_ptr", {7'd0, wr_ptr_a}, 32'd0);

    // ---- wrap on dut_b (LAST_ADDR=3): 6 buffered words ----
    do_reset();
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 1'b1, 8'(j), 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("wrap.level",  {27'd0, level_b}, 32'd6);
    check("wrap.write0", {31'd0, bus_b.avm_write}, 32'd1);
    check("wrap.addr0",  {7'd0, bus_b.avm_address}, seq[0]);
    waitreq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 6) begin
        word = {8'(2 * k + 1), 8'(2 * k)};
        check($sformatf("wrap%0d.write", k), {31'd0, bus_b.avm_write}, 32'd1);
        check($sformatf("wrap%0d.addr", k), {7'd0, bus_b.avm_address}, seq[k]);
        check($sformatf("wrap%0d.data", k), {16'd0, bus_b.avm_writedata}, {16'd0, word});
      end else begin
        check("wrap.end.write",  {31'd0, bus_b.avm_write}, 32'd0);
        check("wrap.end.wr_ptr", {7'd0, wr_ptr_b}, 32'd2);
        check("wrap.end.level",  {27'd0, level_b}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
